// File: rtl/key_pkg.sv
// Shared types and default configuration for the key_pulse_gen input conditioner.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'b00,
      PRESS_WAIT   = 2'b01,
      PRESSED      = 2'b10,
      RELEASE_WAIT = 2'b11
   } key_state_t;

   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_DB_CYCLES     = 16;
   localparam int DEF_HOLD_CYCLES   = 200;
   localparam int DEF_REPEAT_CYCLES = 50;
   localparam int DEF_CNT_W         = 16;

   // Debounced level is high in every state where the key is considered held.
   function automatic logic state_is_down(input key_state_t s);
      return (s == PRESSED) || (s == RELEASE_WAIT);
   endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for one asynchronous bit; synchronous active-low reset to 0.
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/key_pulse_gen.sv
// Synchronizes and debounces a raw key, emitting one registered pulse per accepted press.
// Optional auto-repeat while held is enabled by defining KEY_PULSE_REPEAT_EN.
module key_pulse_gen
   import key_pkg::*;
#(
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int DB_CYCLES     = DEF_DB_CYCLES,
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_in,
   output logic pulse,
   output logic level
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

   generate
      if (SYNC_STAGES < 2 || DB_CYCLES < 1 || REPEAT_CYCLES < 2 || HOLD_CYCLES < 1 ||
          DB_CYCLES > (2**CNT_W - 1) || HOLD_CYCLES > (2**CNT_W - 1) ||
          REPEAT_CYCLES > (2**CNT_W - 1)) begin : g_bad_cfg
         $error("key_pulse_gen: illegal parameter combination");
      end
   endgenerate

   logic             w_sync_q;
   key_state_t       r_state;
   key_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_db_cnt;
   logic [CNT_W-1:0] w_db_cnt_nxt;
   logic             w_press_accept;
   logic             w_enter_pressed;
   logic             w_rpt_fire;
   logic             w_pulse_nxt;
   logic             w_level_nxt;
   logic             r_pulse;
   logic             r_level;

   sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (key_in),
      .o_q   (w_sync_q)
   );

   // State register, debounce counter and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_db_cnt <= '0;
         r_pulse  <= 1'b0;
         r_level  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_db_cnt <= w_db_cnt_nxt;
         r_pulse  <= w_pulse_nxt;
         r_level  <= w_level_nxt;
      end
   end

   // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_nxt    = r_state;
      w_db_cnt_nxt   = r_db_cnt;
      w_press_accept = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_db_cnt_nxt = '0;
            if (w_sync_q) begin
               if (DB_CYCLES == 1) begin
                  w_state_nxt    = PRESSED;
                  w_press_accept = 1'b1;
               end else begin
                  w_state_nxt  = PRESS_WAIT;
                  w_db_cnt_nxt = CNT_W'(1);
               end
            end
         end
         PRESS_WAIT: begin
            if (!w_sync_q) begin
               w_state_nxt  = IDLE;
               w_db_cnt_nxt = '0;
            end else if (r_db_cnt == DB_LAST) begin
               w_state_nxt    = PRESSED;
               w_db_cnt_nxt   = '0;
               w_press_accept = 1'b1;
            end else begin
               w_db_cnt_nxt = r_db_cnt + CNT_W'(1);
            end
         end
         PRESSED: begin
            w_db_cnt_nxt = '0;
            if (!w_sync_q) begin
               if (DB_CYCLES == 1) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt  = RELEASE_WAIT;
                  w_db_cnt_nxt = CNT_W'(1);
               end
            end
         end
         RELEASE_WAIT: begin
            // A bounce back high before acceptance is a glitch: resume PRESSED silently.
            if (w_sync_q) begin
               w_state_nxt  = PRESSED;
               w_db_cnt_nxt = '0;
            end else if (r_db_cnt == DB_LAST) begin
               w_state_nxt  = IDLE;
               w_db_cnt_nxt = '0;
            end else begin
               w_db_cnt_nxt = r_db_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt  = IDLE;
            w_db_cnt_nxt = '0;
         end
      endcase
   end

   assign w_enter_pressed = (w_state_nxt == PRESSED) && (r_state != PRESSED);

`ifdef KEY_PULSE_REPEAT_EN
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);

   logic [CNT_W-1:0] r_rpt_cnt;
   logic [CNT_W-1:0] w_rpt_cnt_nxt;
   logic             r_rpt_armed;
   logic             w_rpt_armed_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rpt_cnt   <= '0;
         r_rpt_armed <= 1'b0;
      end else begin
         r_rpt_cnt   <= w_rpt_cnt_nxt;
         r_rpt_armed <= w_rpt_armed_nxt;
      end
   end

   // First repeat waits HOLD_CYCLES from entry; after that the period is REPEAT_CYCLES.
   always_comb begin
      w_rpt_cnt_nxt   = r_rpt_cnt;
      w_rpt_armed_nxt = r_rpt_armed;
      w_rpt_fire      = 1'b0;
      if (w_enter_pressed) begin
         w_rpt_cnt_nxt   = '0;
         w_rpt_armed_nxt = 1'b0;
      end else if (r_state == PRESSED && w_state_nxt == PRESSED) begin
         if ((!r_rpt_armed && r_rpt_cnt == HOLD_LAST) ||
             ( r_rpt_armed && r_rpt_cnt == RPT_LAST)) begin
            w_rpt_fire      = 1'b1;
            w_rpt_cnt_nxt   = '0;
            w_rpt_armed_nxt = 1'b1;
         end else begin
            w_rpt_cnt_nxt = r_rpt_cnt + CNT_W'(1);
         end
      end
   end
`else
   assign w_rpt_fire = 1'b0;
`endif

   // Output decode: registered next cycle, so outputs align with the new state.
   always_comb begin
      w_pulse_nxt = w_press_accept | w_rpt_fire;
      w_level_nxt = state_is_down(w_state_nxt);
   end

   assign pulse = r_pulse;
   assign level = r_level;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Directed self-checking bench for key_pulse_gen (SYNC=2, DB=4, HOLD=8, REPEAT=3).
module tb_key_pulse_gen;
   import key_pkg::*;

   localparam int SYNC = 2;
   localparam int DB   = 4;
   localparam int HOLD = 8;
   localparam int RPT  = 3;
   localparam int CW   = 16;

   logic clk = 1'b0;
   logic rst_n;
   logic key_in;
   logic pulse;
   logic level;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   key_pulse_gen #(
      .SYNC_STAGES   (SYNC),
      .DB_CYCLES     (DB),
      .HOLD_CYCLES   (HOLD),
      .REPEAT_CYCLES (RPT),
      .CNT_W         (CW)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_in (key_in),
      .pulse  (pulse),
      .level  (level)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive key, take one rising edge, sample 1 time unit later.
   task automatic tick(input logic k);
      key_in = k;
      @(posedge clk);
      #1;
   endtask

   function automatic logic rpt_pulse_exp(input int t);
`ifdef KEY_PULSE_REPEAT_EN
      return (t == 6) || (t == 14) || (t == 17) || (t == 20) ||
             (t == 23) || (t == 26) || (t == 29);
`else
      return (t == 6);
`endif
   endfunction

   initial begin
      int   n_pulses;
      logic prev_pulse;

      rst_n  = 1'b0;
      key_in = 1'b0;

      // Reset with the key held high: everything cleared.
      for (int i = 0; i < 3; i++) tick(1'b1);
      check("reset.pulse", int'(pulse), 0);
      check("reset.level", int'(level), 0);
      check("reset.state", int'(dut.r_state), int'(IDLE));
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) tick(1'b0);
      check("idle.pulse", int'(pulse), 0);
      check("idle.level", int'(level), 0);

      // Clean press: held 20 edges, then low.
      for (int t = 1; t <= 32; t++) begin
         tick(t <= 20);
         check($sformatf("clean.pulse@%0d", t), int'(pulse), int'(t == 6));
         check($sformatf("clean.level@%0d", t), int'(level), int'(t >= 6 && t <= 25));
      end

      // Bounce 1,1,1,0,1,1,1,0: never accepted.
      for (int t = 1; t <= 16; t++) begin
         tick((t <= 8) && (t != 4) && (t != 8));
         check($sformatf("bounce.pulse@%0d", t), int'(pulse), 0);
         check($sformatf("bounce.level@%0d", t), int'(level), 0);
      end
      check("bounce.state", int'(dut.r_state), int'(IDLE));

      // Release glitch: two low cycles while pressed.
      for (int t = 1; t <= 28; t++) begin
         tick((t <= 8) || (t >= 11 && t <= 16));
         check($sformatf("glitch.pulse@%0d", t), int'(pulse), int'(t == 6));
         check($sformatf("glitch.level@%0d", t), int'(level), int'(t >= 6 && t <= 21));
      end

      // Reset in PRESS_WAIT at db_cnt=2, key kept high.
      for (int t = 1; t <= 4; t++) tick(1'b1);
      check("rstmid.state_before", int'(dut.r_state), int'(PRESS_WAIT));
      check("rstmid.db_cnt_before", int'(dut.r_db_cnt), 2);
      rst_n = 1'b0;
      tick(1'b1);
      check("rstmid.pulse", int'(pulse), 0);
      check("rstmid.level", int'(level), 0);
      check("rstmid.state", int'(dut.r_state), int'(IDLE));
      check("rstmid.db_cnt", int'(dut.r_db_cnt), 0);
      rst_n = 1'b1;
      for (int r = 1; r <= 8; r++) begin
         tick(1'b1);
         check($sformatf("rstmid.pulse@%0d", r), int'(pulse), int'(r == 6));
         check($sformatf("rstmid.level@%0d", r), int'(level), int'(r >= 6));
      end
      for (int r = 1; r <= 10; r++) begin
         tick(1'b0);
         check($sformatf("rstmid.rel_level@%0d", r), int'(level), int'(r < 6));
         check($sformatf("rstmid.rel_pulse@%0d", r), int'(pulse), 0);
      end

      // Long hold: auto-repeat pulses only when the feature is built in.
      for (int t = 1; t <= 40; t++) begin
         tick(t <= 29);
         check($sformatf("hold.pulse@%0d", t), int'(pulse), int'(rpt_pulse_exp(t)));
         check($sformatf("hold.level@%0d", t), int'(level), int'(t >= 6 && t <= 34));
      end

      // Three clean presses separated by 10 low cycles.
      n_pulses   = 0;
      prev_pulse = 1'b0;
      for (int p = 0; p < 3; p++) begin
         for (int r = 1; r <= 18; r++) begin
            tick(r <= 8);
            check($sformatf("three%0d.pulse@%0d", p, r), int'(pulse), int'(r == 6));
            check($sformatf("three%0d.level@%0d", p, r), int'(level), int'(r >= 6 && r <= 13));
            check($sformatf("three%0d.consec@%0d", p, r), int'(prev_pulse & pulse), 0);
            if (pulse) n_pulses++;
            prev_pulse = pulse;
         end
      end
      check("three.total_pulses", n_pulses, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
